// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   Memory-access stage that sits directly upstream of writeback.
//   It executes LD / LDI / ST / STI against the data-memory port using a
//   req/ack handshake. The indirect forms (LDI/STI) use two memory phases:
//   first a pointer fetch, then one idle cycle, then the real access.
//   The load result is presented on memout and held until the next load
//   completes.
//
//   Optional feature: define MEMACC_TIMEOUT_EN to add a per-phase ack
//   timeout. A phase that waits TIMEOUT_CYC cycles without mem_ack is
//   aborted, loads return 16'hDEAD, and err is set until the next accepted
//   start. Without the macro, err is tied low and the stage waits forever.
//
// Ports
//   clock, reset   single clock; asynchronous active-high reset
//   start          request a new op (sampled only while busy=0)
//   mem_op         0=LD 1=LDI 2=ST 3=STI, sampled with start
//   addr, st_data  effective address and store data, sampled with start
//   busy           high in every state except IDLE
//   done           one-cycle completion pulse
//   memout         last load result
//   mem_req/mem_we/mem_addr/mem_wdata   memory request, held until acked
//   mem_ack/mem_rdata                   memory response
//   err            ack-timeout flag (MEMACC_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module mem_access_stage #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        mem_op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] st_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] memout,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              err
);

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("mem_access_stage: TIMEOUT_CYC must be at least 1");
   end

   localparam logic [1:0] OP_LD = 2'd0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD1,
      S_GAP,
      S_RD2,
      S_WR,
      S_DONE
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [1:0]        op_q;     // bit1 = store, bit0 = indirect
   logic [ADDR_W-1:0] ptr_q;
   logic              accept;
   logic              in_phase;
   logic              load_done;
   logic              timeout;
   logic              busy_nxt;
   logic              done_nxt;
   logic              req_nxt;
   logic              we_nxt;

   assign accept    = (state == S_IDLE) && start;
   assign in_phase  = (state == S_RD1) || (state == S_RD2) || (state == S_WR);
   assign load_done = mem_ack &&
                      (((state == S_RD1) && (op_q == OP_LD)) || (state == S_RD2));

`ifdef MEMACC_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] wait_cnt;

   // The cycle that would be the TIMEOUT_CYC-th unacknowledged wait aborts the phase.
   assign timeout = in_phase && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         err      <= 1'b0;
      end else begin
         if (next_state != state)
            wait_cnt <= '0;
         else if (in_phase && !mem_ack)
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (accept)
            err <= 1'b0;
         else if (timeout)
            err <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;
`endif

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= next_state;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (start)
               next_state = (mem_op == 2'd2) ? S_WR : S_RD1;
         end
         S_RD1: begin
            if (mem_ack)
               next_state = (op_q == OP_LD) ? S_DONE : S_GAP;
            else if (timeout)
               next_state = S_DONE;
         end
         S_GAP:   next_state = op_q[1] ? S_WR : S_RD2;
         S_RD2,
         S_WR: begin
            if (mem_ack || timeout)
               next_state = S_DONE;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // Output decode from the next state so every output leaves a flop
   always_comb begin
      busy_nxt = (next_state != S_IDLE);
      done_nxt = (next_state == S_DONE);
      req_nxt  = (next_state == S_RD1) || (next_state == S_RD2) || (next_state == S_WR);
      we_nxt   = (next_state == S_WR);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         memout    <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         busy    <= busy_nxt;
         done    <= done_nxt;
         mem_req <= req_nxt;
         mem_we  <= we_nxt;
         // mem_wdata doubles as the latched store data for the STI write phase
         if (accept) begin
            mem_addr  <= addr;
            mem_wdata <= st_data;
         end else if (state == S_GAP) begin
            mem_addr <= ptr_q;
         end
         if (load_done)
            memout <= mem_rdata;
         else if (timeout && !op_q[1])
            memout <= DATA_W'(16'hDEAD);
      end
   end

   // Operation latch and indirect pointer; not reset, only read outside IDLE
   always_ff @(posedge clock) begin
      if (accept)
         op_q <= mem_op;
      if ((state == S_RD1) && mem_ack)
         ptr_q <= mem_rdata[ADDR_W-1:0];
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_access_stage
//   Self-checking bench for mem_access_stage. A behavioural memory answers
//   requests after a programmable number of wait cycles; each operation pushes
//   its expected memory accesses and its expected result (latency, memout)
//   into scoreboard queues that are popped when the DUT acts.
// ---------------------------------------------------------------------------
module tb_mem_access_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  mem_op;
   logic [15:0] addr;
   logic [15:0] st_data;
   logic        busy;
   logic        done;
   logic [15:0] memout;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        err;

   mem_access_stage #(
      .DATA_W      (16),
      .ADDR_W      (16),
      .TIMEOUT_CYC (15)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .mem_op    (mem_op),
      .addr      (addr),
      .st_data   (st_data),
      .busy      (busy),
      .done      (done),
      .memout    (memout),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .err       (err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        we;
      logic [15:0] a;
      logic [15:0] d;
   } acc_t;

   typedef struct {
      int          lat;
      logic [15:0] mo;
   } res_t;

   acc_t        exp_acc[$];
   res_t        exp_res[$];
   logic [15:0] mem [logic [15:0]];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          ack_delay = 0;
   bit          resp_en   = 1'b1;
   logic [15:0] exp_memout = 16'h0000;

   function automatic logic [15:0] rd(input logic [15:0] a);
      return mem.exists(a) ? mem[a] : 16'h0000;
   endfunction

   // Behavioural memory: acks after ack_delay wait cycles, checks that the
   // request is held stable while waiting and matches the expected access.
   initial begin : responder
      int          wait_ctr;
      logic        hold_we;
      logic [15:0] hold_a;
      logic [15:0] hold_d;
      acc_t        e;
      wait_ctr  = 0;
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      hold_we   = 1'b0;
      hold_a    = 16'h0000;
      hold_d    = 16'h0000;
      forever begin
         @(posedge clock);
         #1;
         if (resp_en) begin
            if (mem_req === 1'b1) begin
               if (wait_ctr == 0) begin
                  hold_we = mem_we;
                  hold_a  = mem_addr;
                  hold_d  = mem_wdata;
               end else begin
                  n_checks++;
                  if (mem_we !== hold_we || mem_addr !== hold_a || (hold_we && mem_wdata !== hold_d)) begin
                     n_fail++;
                     $display("FAIL req_stable: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                              mem_we, mem_addr, mem_wdata, hold_we, hold_a, hold_d);
                  end
               end
               if (wait_ctr == ack_delay) begin
                  mem_ack  = 1'b1;
                  wait_ctr = 0;
                  if (mem_we)
                     mem[mem_addr] = mem_wdata;
                  else
                     mem_rdata = rd(mem_addr);
                  n_checks++;
                  if (exp_acc.size() == 0) begin
                     n_fail++;
                     $display("FAIL access: unexpected we=%b addr=%h wdata=%h, required no access",
                              mem_we, mem_addr, mem_wdata);
                  end else begin
                     e = exp_acc.pop_front();
                     if (mem_we !== e.we || mem_addr !== e.a || (e.we && mem_wdata !== e.d)) begin
                        n_fail++;
                        $display("FAIL access: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 mem_we, mem_addr, mem_wdata, e.we, e.a, e.d);
                     end
                  end
               end else begin
                  mem_ack = 1'b0;
                  wait_ctr++;
               end
            end else begin
               mem_ack  = 1'b0;
               wait_ctr = 0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   // Issue one op, push its expected accesses and result, then wait for done.
   task automatic run_op(input logic [1:0] op, input logic [15:0] a,
                         input logic [15:0] d, input int exp_lat);
      res_t        r;
      int          lat;
      logic [15:0] p;
      p = rd(a);
      case (op)
         2'd0: begin
            exp_acc.push_back({1'b0, a, 16'h0000});
            exp_memout = rd(a);
         end
         2'd1: begin
            exp_acc.push_back({1'b0, a, 16'h0000});
            exp_acc.push_back({1'b0, p, 16'h0000});
            exp_memout = rd(p);
         end
         2'd2: exp_acc.push_back({1'b1, a, d});
         default: begin
            exp_acc.push_back({1'b0, a, 16'h0000});
            exp_acc.push_back({1'b1, p, d});
         end
      endcase
      r.lat = exp_lat;
      r.mo  = exp_memout;
      exp_res.push_back(r);
      start   = 1'b1;
      mem_op  = op;
      addr    = a;
      st_data = d;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 200) begin
         @(posedge clock);
         #1;
         lat++;
      end
      r = exp_res.pop_front();
      n_checks++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL done_seen op=%0d: got done=%b after %0d cycles, required 1", op, done, lat);
      end
      n_checks++;
      if (lat != r.lat) begin
         n_fail++;
         $display("FAIL latency op=%0d: got %0d, required %0d", op, lat, r.lat);
      end
      n_checks++;
      if (memout !== r.mo) begin
         n_fail++;
         $display("FAIL memout op=%0d: got %h, required %h", op, memout, r.mo);
      end
      n_checks++;
      if (busy !== 1'b1 || mem_req !== 1'b0 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL done_cycle op=%0d: got busy=%b mem_req=%b err=%b, required 1 0 0",
                  op, busy, mem_req, err);
      end
      @(posedge clock);
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || exp_acc.size() != 0) begin
         n_fail++;
         $display("FAIL after_done op=%0d: got done=%b busy=%b pending=%0d, required 0 0 0",
                  op, done, busy, exp_acc.size());
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      start   = 1'b0;
      mem_op  = 2'd0;
      addr    = 16'h0000;
      st_data = 16'h0000;
      #12;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0 ||
          memout !== 16'h0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b done=%b req=%b we=%b err=%b memout=%h addr=%h wdata=%h, required all 0",
                  busy, done, mem_req, mem_we, err, memout, mem_addr, mem_wdata);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_ld();
      mem[16'h3000] = 16'h1234;
      mem[16'h3010] = 16'h7F00;
      ack_delay = 0;
      run_op(2'd0, 16'h3000, 16'h0000, 2);
      ack_delay = 1;
      run_op(2'd0, 16'h3010, 16'h0000, 3);
      ack_delay = 0;
   endtask

   task automatic test_ldi();
      mem[16'h3001] = 16'h4000;
      mem[16'h4000] = 16'h8001;
      ack_delay = 0;
      run_op(2'd1, 16'h3001, 16'h0000, 4);
   endtask

   task automatic test_sti_wait();
      mem[16'h3002] = 16'h5000;
      mem[16'h5000] = 16'h0000;
      ack_delay = 3;
      run_op(2'd3, 16'h3002, 16'hBEEF, 10);
      ack_delay = 0;
      n_checks++;
      if (rd(16'h5000) !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL sti_write: got mem[5000]=%h, required beef", rd(16'h5000));
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      ack_delay = 2;
      mem[16'hFFFF] = 16'h5555;
      exp_acc.push_back({1'b1, 16'hFFFF, 16'h0000});
      start   = 1'b1;
      mem_op  = 2'd2;
      addr    = 16'hFFFF;
      st_data = 16'h0000;
      @(posedge clock);
      #1;
      // start stays high with a different op while busy; it must be ignored
      mem_op  = 2'd0;
      addr    = 16'h3000;
      st_data = 16'h1111;
      lat = 1;
      while (done !== 1'b1 && lat < 50) begin
         @(posedge clock);
         #1;
         lat++;
      end
      n_checks++;
      if (done !== 1'b1 || lat != 4) begin
         n_fail++;
         $display("FAIL st_latency: got done=%b lat=%0d, required 1 4", done, lat);
      end
      n_checks++;
      if (memout !== exp_memout || rd(16'hFFFF) !== 16'h0000 || exp_acc.size() != 0) begin
         n_fail++;
         $display("FAIL st_result: got memout=%h mem[ffff]=%h pending=%0d, required %h 0000 0",
                  memout, rd(16'hFFFF), exp_acc.size(), exp_memout);
      end
      // start still high during the DONE cycle: ignored; accepted in the following IDLE cycle
      ack_delay = 0;
      exp_acc.push_back({1'b0, 16'h3000, 16'h0000});
      exp_memout = rd(16'h3000);
      @(posedge clock);
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL start_in_done: got busy=%b done=%b, required 0 0", busy, done);
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 16'h3000 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_accept: got busy=%b req=%b addr=%h we=%b, required 1 1 3000 0",
                  busy, mem_req, mem_addr, mem_we);
      end
      @(posedge clock);
      #1;
      n_checks++;
      if (done !== 1'b1 || memout !== exp_memout) begin
         n_fail++;
         $display("FAIL b2b_done: got done=%b memout=%h, required 1 %h", done, memout, exp_memout);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset_mid_op();
      ack_delay = 0;
      exp_acc.push_back({1'b0, 16'h3001, 16'h0000});
      start   = 1'b1;
      mem_op  = 2'd1;
      addr    = 16'h3001;
      st_data = 16'h0000;
      @(posedge clock);
      #1;
      start = 1'b0;
      @(posedge clock);
      #1;
      resp_en = 1'b0;
      mem_ack = 1'b0;
      @(posedge clock);
      #1;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'h4000 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL rd2_phase: got req=%b addr=%h we=%b, required 1 4000 0", mem_req, mem_addr, mem_we);
      end
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || memout !== 16'h0000) begin
         n_fail++;
         $display("FAIL async_reset: got req=%b busy=%b done=%b memout=%h, required 0 0 0 0000",
                  mem_req, busy, done, memout);
      end
      @(posedge clock);
      #1;
      reset      = 1'b0;
      exp_memout = 16'h0000;
      mem_ack    = 1'b1;
      mem_rdata  = 16'hABCD;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         n_checks++;
         if (done !== 1'b0 || busy !== 1'b0 || mem_req !== 1'b0 || memout !== 16'h0000) begin
            n_fail++;
            $display("FAIL late_ack[%0d]: got done=%b busy=%b req=%b memout=%h, required 0 0 0 0000",
                     i, done, busy, mem_req, memout);
         end
      end
      mem_ack = 1'b0;
      resp_en = 1'b1;
      n_checks++;
      if (exp_acc.size() != 0) begin
         n_fail++;
         $display("FAIL reset_accesses: got %0d pending, required 0", exp_acc.size());
      end
      // the stage must be usable again after the abort
      run_op(2'd1, 16'h3001, 16'h0000, 4);
   endtask

`ifdef MEMACC_TIMEOUT_EN
   task automatic test_timeout();
      int lat;
      resp_en = 1'b0;
      mem_ack = 1'b0;
      start   = 1'b1;
      mem_op  = 2'd0;
      addr    = 16'h3000;
      st_data = 16'h0000;
      @(posedge clock);
      #1;
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clock);
         #1;
         lat++;
      end
      n_checks++;
      if (done !== 1'b1 || lat != 16 || err !== 1'b1 || memout !== 16'hDEAD) begin
         n_fail++;
         $display("FAIL timeout: got done=%b lat=%0d err=%b memout=%h, required 1 16 1 dead",
                  done, lat, err, memout);
      end
      @(posedge clock);
      #1;
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL err_hold: got err=%b busy=%b, required 1 0", err, busy);
      end
      resp_en    = 1'b1;
      exp_memout = 16'hDEAD;
      run_op(2'd0, 16'h3000, 16'h0000, 2);
   endtask
`else
   task automatic test_long_wait();
      ack_delay = 20;
      run_op(2'd0, 16'h3000, 16'h0000, 22);
      ack_delay = 0;
   endtask
`endif

   initial begin : main
      test_reset();
      test_ld();
      test_ldi();
      test_sti_wait();
      test_back_to_back();
      test_reset_mid_op();
`ifdef MEMACC_TIMEOUT_EN
      test_timeout();
`else
      test_long_wait();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
